// File: rtl/led_pwm_array.sv
// led_pwm_array -- multi-channel LED PWM generator with a shared prescaled
// slot counter and double-buffered per-channel duty registers.
//
// Optional feature macro: LED_PWM_BREATHE_EN. When it is defined, each channel
// can ramp its brightness up and down automatically (breathing mode). When it
// is undefined, the breathe input is ignored and no breath state is built.
//
// Ports (led_pwm_array):
//   clock        in   system clock; all logic on its rising edge
//   reset        in   synchronous, active-low reset
//   enable       in   1: PWM runs; 0: counters hold and outputs forced low
//   duty_in      in   packed duties, channel i at [i*WIDTH +: WIDTH]
//   duty_load    in   strobe; captures duty_in into the pending registers
//   breathe      in   per-channel breathing select (feature builds only)
//   pwm_out      out  registered PWM outputs, high = LED on
//   period_tick  out  one-clock pulse when the slot counter wraps to 0
//
// Ports (led_pwm_lane, one per channel):
//   clock, reset, enable   as above
//   boundary     in   slot counter is wrapping on this edge
//   duty_load    in   capture duty into pending
//   duty         in   this channel's slice of duty_in
//   breathe      in   this channel's breathing select
//   slot_next    in   slot counter value after this edge
//   pwm          out  registered PWM output

module led_pwm_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             boundary,
  input  logic             duty_load,
  input  logic [WIDTH-1:0] duty,
  input  logic             breathe,
  input  logic [WIDTH-1:0] slot_next,
  output logic             pwm
);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] active_next;
  logic [WIDTH-1:0] level_sel;

  // Pending duty accepts loads on any cycle, including while disabled.
  always_ff @(posedge clock) begin
    if (!reset)         pending <= '0;
    else if (duty_load) pending <= duty;
  end

  // Active duty only changes at a period boundary. A load landing on the
  // boundary itself bypasses pending so it governs the period starting now.
  always_comb begin
    active_next = active;
    if (boundary) active_next = duty_load ? duty : pending;
  end

  always_ff @(posedge clock) begin
    if (!reset) active <= '0;
    else        active <= active_next;
  end

`ifdef LED_PWM_BREATHE_EN
  typedef struct packed {
    logic             down;   // 0 = ramping up, 1 = ramping down
    logic [WIDTH-1:0] level;
  } breath_t;

  breath_t breath, breath_next;
  logic    rising;

  // A channel ramping down turns around at 0; one ramping up turns around
  // at the active duty. Evaluated against the duty of the new period.
  assign rising = breath.down ? (breath.level == '0)
                              : (breath.level < active_next);

  always_comb begin
    breath_next = breath;
    if (!breathe) begin
      breath_next.level = '0;
      breath_next.down  = 1'b0;
    end else if (boundary) begin
      if (active_next < breath.level) begin
        // Duty dropped under the current level: clamp and head down.
        breath_next.level = active_next;
        breath_next.down  = 1'b1;
      end else if (rising) begin
        if (breath.level < active_next) begin
          breath_next.level = breath.level + WIDTH'(1);
          breath_next.down  = (breath.level + WIDTH'(1) == active_next);
        end else begin
          breath_next.down  = 1'b0;   // level and duty both 0: park at 0
        end
      end else begin
        if (breath.level != '0) begin
          breath_next.level = breath.level - WIDTH'(1);
          breath_next.down  = (breath.level - WIDTH'(1) != '0);
        end else begin
          breath_next.down  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) breath <= '0;
    else        breath <= breath_next;
  end

  assign level_sel = breathe ? breath_next.level : active_next;
`else
  logic breathe_unused;
  assign breathe_unused = breathe;
  assign level_sel      = active_next;
`endif

  // Compare against the post-edge counter and level so pwm lines up with the
  // slot counter register in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) pwm <= 1'b0;
    else        pwm <= enable && (slot_next < level_sel);
  end

endmodule

module led_pwm_array #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 46
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      duty_load,
  input  logic [CHANNELS-1:0]       breathe,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick
);

  localparam int               PW       = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PW-1:0]    PS_TC    = PW'(PRESCALE);
  localparam logic [WIDTH-1:0] SLOT_MAX = '1;

  logic [PW-1:0]                     prescaler;
  logic [WIDTH-1:0]                  slot;
  logic [WIDTH-1:0]                  slot_next;
  logic                              slot_en;
  logic                              boundary;
  logic [CHANNELS-1:0][WIDTH-1:0]    duty_lane;

  assign slot_en   = enable && (prescaler == PS_TC);
  assign boundary  = slot_en && (slot == SLOT_MAX);
  assign slot_next = slot_en ? slot + WIDTH'(1) : slot;
  assign duty_lane = duty_in;

  // Prescaler and slot counter both freeze while disabled so a resumed
  // period finishes with the correct remaining on-time.
  always_ff @(posedge clock) begin
    if (!reset)      prescaler <= '0;
    else if (enable) prescaler <= (prescaler == PS_TC) ? '0 : prescaler + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot        <= '0;
      period_tick <= 1'b0;
    end else begin
      slot        <= slot_next;
      period_tick <= boundary;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    led_pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .boundary  (boundary),
      .duty_load (duty_load),
      .duty      (duty_lane[i]),
      .breathe   (breathe[i]),
      .slot_next (slot_next),
      .pwm       (pwm_out[i])
    );
  end

endmodule
